// File: rtl/tile_ram_arbiter.sv
// Tile map RAM shared by a VGA renderer (priority reader) and a handshaked update port.
// After reset or a clear request, the RAM is swept to an empty field surrounded by walls.
module tile_ram_arbiter #(
  parameter int MAPA_WIDTH  = 40,
  parameter int MAPA_HEIGHT = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vga_read,
  input  logic [9:0] renderer_rx,
  input  logic [9:0] renderer_ry,
  output logic [7:0] mapa_R,
  output logic [7:0] mapa_G,
  output logic [7:0] mapa_B,
  input  logic       update_renable,
  input  logic [9:0] update_rx,
  input  logic [9:0] update_ry,
  output logic [3:0] update_rdata,
  output logic       update_rvalid,
  input  logic       update_wenable,
  input  logic [9:0] update_wx,
  input  logic [9:0] update_wy,
  input  logic [3:0] update_wdata,
  output logic       update_wack,
  output logic       update_ready,
  input  logic       clear_req,
  output logic       busy
);

  localparam int         DEPTH      = MAPA_WIDTH * MAPA_HEIGHT;
  localparam int         ADDR_W     = 11;
  localparam logic [3:0] TILE_EMPTY = 4'd0;
  localparam logic [3:0] TILE_WALL  = 4'd5;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  function automatic logic [23:0] palette(input logic [3:0] code);
    logic [23:0] rgb;
    case (code)
      4'd0:    rgb = 24'h000000;
      4'd1:    rgb = 24'h00C000;
      4'd2:    rgb = 24'h00FF00;
      4'd3:    rgb = 24'hFF0000;
      4'd4:    rgb = 24'h808080;
      4'd5:    rgb = 24'hFFFFFF;
      default: rgb = 24'hFF00FF;
    endcase
    return rgb;
  endfunction

  function automatic logic in_range(input logic [9:0] x, input logic [9:0] y);
    return (x < 10'(MAPA_WIDTH)) && (y < 10'(MAPA_HEIGHT));
  endfunction

  function automatic logic [ADDR_W-1:0] tile_addr(input logic [9:0] x, input logic [9:0] y);
    return ADDR_W'(y) * ADDR_W'(MAPA_WIDTH) + ADDR_W'(x);
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic                busy_s;
  logic                idle_s;
  logic [ADDR_W-1:0]   clr_cnt_r;
  logic [9:0]          clr_x_r;
  logic [9:0]          clr_y_r;
  logic                clr_last_s;
  logic                clr_wall_s;

  logic [3:0]          mem_r [DEPTH];
  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_waddr_s;
  logic [3:0]          mem_wdata_s;

  logic                grant_s;
  logic                wr_grant_s;
  logic                rd_grant_s;
  logic                wr_in_range_s;
  logic                rd_in_range_s;
  logic                rend_in_range_s;
  logic [ADDR_W-1:0]   wr_addr_s;
  logic [ADDR_W-1:0]   rd_addr_s;
  logic [ADDR_W-1:0]   rend_addr_s;

  logic                wack_r;
  logic                rvalid_r;
  logic [3:0]          rdata_r;
  logic [23:0]         rgb_r;

  assign clr_last_s = (clr_cnt_r == ADDR_W'(DEPTH - 1));
  assign clr_wall_s = (clr_x_r == 10'd0) || (clr_x_r == 10'(MAPA_WIDTH - 1)) ||
                      (clr_y_r == 10'd0) || (clr_y_r == 10'(MAPA_HEIGHT - 1));

  assign wr_in_range_s   = in_range(update_wx, update_wy);
  assign rd_in_range_s   = in_range(update_rx, update_ry);
  assign rend_in_range_s = in_range(renderer_rx, renderer_ry);
  assign wr_addr_s       = tile_addr(update_wx, update_wy);
  assign rd_addr_s       = tile_addr(update_rx, update_ry);
  assign rend_addr_s     = tile_addr(renderer_rx, renderer_ry);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_CLEAR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: sweep runs to the last address; clear requests only matter in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_last_s) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_CLEAR;
      end
      ST_IDLE: begin
        if (clear_req) state_nxt_s = ST_CLEAR;
        else           state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_CLEAR;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy_s = 1'b1;
    idle_s = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        busy_s = 1'b1;
        idle_s = 1'b0;
      end
      ST_IDLE: begin
        busy_s = 1'b0;
        idle_s = 1'b1;
      end
      default: begin
        busy_s = 1'b1;
        idle_s = 1'b0;
      end
    endcase
  end

  assign busy         = busy_s;
  assign update_ready = idle_s & ~vga_read;

  // A held request that has just been acknowledged must not be accepted a second time.
  assign grant_s    = update_ready & ~(wack_r | rvalid_r);
  assign wr_grant_s = grant_s & update_wenable;
  assign rd_grant_s = grant_s & ~update_wenable & update_renable;

  // Sweep address counter with x/y tracking for border detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_cnt_r <= {ADDR_W{1'b0}};
      clr_x_r   <= 10'd0;
      clr_y_r   <= 10'd0;
    end else if ((state_r == ST_CLEAR) && !clr_last_s) begin
      clr_cnt_r <= clr_cnt_r + ADDR_W'(1);
      if (clr_x_r == 10'(MAPA_WIDTH - 1)) begin
        clr_x_r <= 10'd0;
        clr_y_r <= clr_y_r + 10'd1;
      end else begin
        clr_x_r <= clr_x_r + 10'd1;
      end
    end else begin
      clr_cnt_r <= {ADDR_W{1'b0}};
      clr_x_r   <= 10'd0;
      clr_y_r   <= 10'd0;
    end
  end

  // RAM write port selection: sweep first, otherwise a granted in-range update write.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = clr_cnt_r;
    mem_wdata_s = TILE_EMPTY;
    if (state_r == ST_CLEAR) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_cnt_r;
      mem_wdata_s = clr_wall_s ? TILE_WALL : TILE_EMPTY;
    end else if (wr_grant_s && wr_in_range_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = wr_addr_s;
      mem_wdata_s = update_wdata;
    end else begin
      mem_we_s    = 1'b0;
      mem_waddr_s = clr_cnt_r;
      mem_wdata_s = TILE_EMPTY;
    end
  end

  // Tile RAM storage.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Update-port responses; read data holds until the next granted read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wack_r   <= 1'b0;
      rvalid_r <= 1'b0;
      rdata_r  <= 4'd0;
    end else begin
      wack_r   <= wr_grant_s;
      rvalid_r <= rd_grant_s;
      if (rd_grant_s) begin
        rdata_r <= rd_in_range_s ? mem_r[rd_addr_s] : 4'd0;
      end
    end
  end

  // Renderer colour: black while sweeping or off-map, held between strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_r <= 24'h000000;
    end else if (vga_read) begin
      rgb_r <= (idle_s && rend_in_range_s) ? palette(mem_r[rend_addr_s]) : 24'h000000;
    end
  end

  assign update_wack   = wack_r;
  assign update_rvalid = rvalid_r;
  assign update_rdata  = rdata_r;
  assign mapa_R        = rgb_r[23:16];
  assign mapa_G        = rgb_r[15:8];
  assign mapa_B        = rgb_r[7:0];

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Randomized self-checking bench for tile_ram_arbiter against an array model of the map.
module tb_tile_ram_arbiter;
  localparam int W = 40;
  localparam int H = 30;

  logic       clk = 1'b0;
  logic       reset;
  logic       vga_read;
  logic [9:0] renderer_rx, renderer_ry;
  logic [7:0] mapa_R, mapa_G, mapa_B;
  logic       update_renable;
  logic [9:0] update_rx, update_ry;
  logic [3:0] update_rdata;
  logic       update_rvalid;
  logic       update_wenable;
  logic [9:0] update_wx, update_wy;
  logic [3:0] update_wdata;
  logic       update_wack;
  logic       update_ready;
  logic       clear_req;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int model [W*H];

  tile_ram_arbiter #(.MAPA_WIDTH(W), .MAPA_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .vga_read(vga_read),
    .renderer_rx(renderer_rx), .renderer_ry(renderer_ry),
    .mapa_R(mapa_R), .mapa_G(mapa_G), .mapa_B(mapa_B),
    .update_renable(update_renable), .update_rx(update_rx), .update_ry(update_ry),
    .update_rdata(update_rdata), .update_rvalid(update_rvalid),
    .update_wenable(update_wenable), .update_wx(update_wx), .update_wy(update_wy),
    .update_wdata(update_wdata), .update_wack(update_wack), .update_ready(update_ready),
    .clear_req(clear_req), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] colour_of(input int code);
    case (code)
      0:       return 24'h000000;
      1:       return 24'h00C000;
      2:       return 24'h00FF00;
      3:       return 24'hFF0000;
      4:       return 24'h808080;
      5:       return 24'hFFFFFF;
      default: return 24'hFF00FF;
    endcase
  endfunction

  function automatic void model_clear();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        model[y*W + x] = (x == 0 || x == W-1 || y == 0 || y == H-1) ? 5 : 0;
  endfunction

  function automatic int model_rd(input int x, input int y);
    if (x < W && y < H) return model[y*W + x];
    return 0;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_write(input int x, input int y, input int d, output int lat);
    tick(1);
    update_wx = 10'(x); update_wy = 10'(y); update_wdata = 4'(d);
    update_wenable = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (update_wack !== 1'b1 && lat < 40);
    update_wenable = 1'b0;
    if (x < W && y < H) model[y*W + x] = d;
  endtask

  task automatic drive_read(input int x, input int y, output int lat, output logic [3:0] data);
    tick(1);
    update_rx = 10'(x); update_ry = 10'(y);
    update_renable = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (update_rvalid !== 1'b1 && lat < 40);
    update_renable = 1'b0;
    data = update_rdata;
  endtask

  task automatic vga_sample(input int x, input int y, output logic [23:0] rgb);
    renderer_rx = 10'(x); renderer_ry = 10'(y);
    vga_read = 1'b1;
    @(posedge clk); #1;
    vga_read = 1'b0;
    rgb = {mapa_R, mapa_G, mapa_B};
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin n++; @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    logic [31:0] obs;
    int n;
    reset = 1'b0;
    tick(3);
    obs = {busy, update_ready, update_wack, update_rvalid, update_rdata, mapa_R, mapa_G, mapa_B};
    n_tests++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 24'd0}) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 24'd0});
    end
    reset = 1'b1;
    count_busy(n);
    n_tests++;
    if (n !== 1200) begin n_fail++; $display("FAIL reset_sweep_len: got %0d expected 1200", n); end
    model_clear();
  endtask

  task automatic test_basic_reads();
    int lat; logic [3:0] d;
    drive_read(5, 5, lat, d);
    n_tests++;
    if (lat !== 1 || d !== 4'd0) begin n_fail++; $display("FAIL read_5_5: got lat=%0d data=%0d expected lat=1 data=0", lat, d); end
    drive_read(0, 0, lat, d);
    n_tests++;
    if (lat !== 1 || d !== 4'd5) begin n_fail++; $display("FAIL read_0_0: got lat=%0d data=%0d expected lat=1 data=5", lat, d); end
    tick(5);
    n_tests++;
    if (update_rdata !== 4'd5 || update_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL rdata_hold: got rdata=%0d rvalid=%b expected 5 0", update_rdata, update_rvalid);
    end
  endtask

  task automatic test_write_read();
    int lat; logic [3:0] d; logic [23:0] rgb;
    drive_write(10, 7, 3, lat);
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL write_10_7_lat: got %0d expected 1", lat); end
    drive_read(10, 7, lat, d);
    n_tests++;
    if (lat !== 1 || d !== 4'd3) begin n_fail++; $display("FAIL read_10_7: got lat=%0d data=%0d expected lat=1 data=3", lat, d); end
    vga_sample(10, 7, rgb);
    n_tests++;
    if (rgb !== 24'hFF0000) begin n_fail++; $display("FAIL vga_10_7: got %h expected ff0000", rgb); end
    tick(4);
    n_tests++;
    if ({mapa_R, mapa_G, mapa_B} !== 24'hFF0000) begin
      n_fail++; $display("FAIL vga_hold: got %h expected ff0000", {mapa_R, mapa_G, mapa_B});
    end
  endtask

  task automatic test_vga_priority();
    int bad = 0;
    tick(1);
    renderer_rx = 10'd10; renderer_ry = 10'd7; vga_read = 1'b1;
    update_wx = 10'd20; update_wy = 10'd10; update_wdata = 4'd4; update_wenable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (update_ready !== 1'b0 || update_wack !== 1'b0 || {mapa_R, mapa_G, mapa_B} !== 24'hFF0000) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL vga_blocks_update: got %0d bad cycles expected 0", bad); end
    vga_read = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (update_wack !== 1'b1) begin n_fail++; $display("FAIL wack_after_vga: got %b expected 1", update_wack); end
    update_wenable = 1'b0;
    model[10*W + 20] = 4;
  endtask

  task automatic test_both_enables();
    int wack_cyc = -1, rv_cyc = -1, wacks = 0, overlap = 0;
    logic [3:0] d = 4'hX;
    tick(1);
    update_wx = 10'd3; update_wy = 10'd3; update_wdata = 4'd2;
    update_rx = 10'd3; update_ry = 10'd3;
    update_wenable = 1'b1; update_renable = 1'b1;
    for (int c = 1; c <= 12 && rv_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (update_wack === 1'b1 && update_rvalid === 1'b1) overlap++;
      if (update_wack === 1'b1) begin wacks++; wack_cyc = c; update_wenable = 1'b0; end
      if (update_rvalid === 1'b1) begin rv_cyc = c; d = update_rdata; update_renable = 1'b0; end
    end
    update_wenable = 1'b0; update_renable = 1'b0;
    model[3*W + 3] = 2;
    n_tests++;
    if (wack_cyc !== 1 || wacks !== 1) begin n_fail++; $display("FAIL both_wack: got cycle %0d count %0d expected 1 1", wack_cyc, wacks); end
    n_tests++;
    if (rv_cyc <= wack_cyc || overlap !== 0) begin
      n_fail++; $display("FAIL both_rvalid_order: got rvalid cycle %0d wack cycle %0d overlap %0d", rv_cyc, wack_cyc, overlap);
    end
    n_tests++;
    if (d !== 4'd2) begin n_fail++; $display("FAIL both_rdata: got %0d expected 2", d); end
  endtask

  task automatic test_back_to_back();
    int wacks = 0, rvs = 0;
    tick(1);
    update_wx = 10'd12; update_wy = 10'd12; update_wdata = 4'd1; update_wenable = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (update_wack === 1'b1) wacks++;
      if (c == 1) update_wenable = 1'b0;
    end
    model[12*W + 12] = 1;
    n_tests++;
    if (wacks !== 1) begin n_fail++; $display("FAIL late_drop_wack_count: got %0d expected 1", wacks); end
    update_rx = 10'd12; update_ry = 10'd12; update_renable = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (update_rvalid === 1'b1) rvs++;
      if (c == 1) update_renable = 1'b0;
    end
    n_tests++;
    if (rvs !== 1 || update_rdata !== 4'd1) begin
      n_fail++; $display("FAIL late_drop_read: got count %0d data %0d expected 1 1", rvs, update_rdata);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic [3:0] d; logic [23:0] rgb;
    drive_write(40, 0, 3, lat);
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL oor_write_wack: got lat %0d expected 1", lat); end
    drive_read(0, 1, lat, d);
    n_tests++;
    if (d !== 4'd5) begin n_fail++; $display("FAIL oor_write_no_alias: got %0d expected 5", d); end
    drive_read(0, 30, lat, d);
    n_tests++;
    if (lat !== 1 || d !== 4'd0) begin n_fail++; $display("FAIL oor_read: got lat=%0d data=%0d expected lat=1 data=0", lat, d); end
    vga_sample(0, 0, rgb);
    vga_sample(45, 2, rgb);
    n_tests++;
    if (rgb !== 24'h000000) begin n_fail++; $display("FAIL oor_vga: got %h expected 000000", rgb); end
  endtask

  task automatic test_random();
    int lat, x, y, dv, op, bad = 0;
    logic [3:0] d; logic [23:0] rgb;
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 2);
      x  = $urandom_range(0, W + 4);
      y  = $urandom_range(0, H + 3);
      dv = $urandom_range(0, 15);
      case (op)
        0: begin
          drive_write(x, y, dv, lat);
          n_tests++;
          if (lat !== 1) begin n_fail++; bad++; $display("FAIL rnd_write (%0d,%0d): got lat %0d expected 1", x, y, lat); end
        end
        1: begin
          drive_read(x, y, lat, d);
          n_tests++;
          if (lat !== 1 || int'(d) !== model_rd(x, y)) begin
            n_fail++; $display("FAIL rnd_read (%0d,%0d): got lat=%0d data=%0d expected lat=1 data=%0d", x, y, lat, d, model_rd(x, y));
          end
        end
        default: begin
          vga_sample(x, y, rgb);
          n_tests++;
          if (rgb !== colour_of(model_rd(x, y))) begin
            n_fail++; $display("FAIL rnd_vga (%0d,%0d): got %h expected %h", x, y, rgb, colour_of(model_rd(x, y)));
          end
        end
      endcase
    end
  endtask

  task automatic test_clear();
    int lat, n; logic [3:0] d; logic [23:0] rgb;
    drive_write(10, 7, 3, lat);
    clear_req = 1'b1; tick(1); clear_req = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || update_ready !== 1'b0) begin
      n_fail++; $display("FAIL clear_start: got busy=%b ready=%b expected 1 0", busy, update_ready);
    end
    vga_sample(10, 7, rgb);
    n_tests++;
    if (rgb !== 24'h000000) begin n_fail++; $display("FAIL vga_in_clear: got %h expected 000000", rgb); end
    clear_req = 1'b1; tick(1); clear_req = 1'b0;
    count_busy(n);
    n_tests++;
    if (n + 2 !== 1200) begin n_fail++; $display("FAIL clear_sweep_len: got %0d expected 1200", n + 2); end
    model_clear();
    drive_read(10, 7, lat, d);
    n_tests++;
    if (d !== 4'd0) begin n_fail++; $display("FAIL clear_10_7: got %0d expected 0", d); end
  endtask

  task automatic test_reset_mid_sweep();
    int lat, n; logic [3:0] d; logic [23:0] rgb;
    logic [31:0] obs;
    drive_write(1, 1, 2, lat);
    vga_sample(1, 1, rgb);
    n_tests++;
    if (rgb !== 24'h00FF00) begin n_fail++; $display("FAIL vga_head: got %h expected 00ff00", rgb); end
    drive_read(1, 1, lat, d);
    clear_req = 1'b1; tick(1); clear_req = 1'b0;
    tick(600);
    reset = 1'b0;
    #1;
    obs = {busy, update_ready, update_wack, update_rvalid, update_rdata, mapa_R, mapa_G, mapa_B};
    n_tests++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 24'd0}) begin
      n_fail++; $display("FAIL midsweep_reset_outputs: got %h expected %h", obs, {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 24'd0});
    end
    tick(2);
    reset = 1'b1;
    count_busy(n);
    n_tests++;
    if (n !== 1200) begin n_fail++; $display("FAIL midsweep_restart_len: got %0d expected 1200", n); end
    model_clear();
    drive_read(1, 1, lat, d);
    n_tests++;
    if (d !== 4'd0) begin n_fail++; $display("FAIL after_reset_1_1: got %0d expected 0", d); end
    drive_read(39, 29, lat, d);
    n_tests++;
    if (d !== 4'd5) begin n_fail++; $display("FAIL after_reset_corner: got %0d expected 5", d); end
  endtask

  initial begin
    reset = 1'b0; vga_read = 1'b0; renderer_rx = 10'd0; renderer_ry = 10'd0;
    update_renable = 1'b0; update_rx = 10'd0; update_ry = 10'd0;
    update_wenable = 1'b0; update_wx = 10'd0; update_wy = 10'd0; update_wdata = 4'd0;
    clear_req = 1'b0;
    #1;
    test_reset();
    test_basic_reads();
    test_write_read();
    test_vga_priority();
    test_both_enables();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_clear();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
